input_conditioner: RTL and testbench

Front-end stage that feeds the Main_clock top. It synchronizes and debounces the five raw push buttons and the four mode slide switches. It then delivers:
- clean button levels and one-press pulses
- a sanitized one-hot mode vector (MODE0..MODE4 encoding)

All logic runs on MCLK. Pulses are stretched so the CLOCK_1ms-domain mode blocks see each press exactly once.

---
 rtl/input_conditioner.sv | 152 +++++++++++++++
 tb/tb_input_conditioner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Button/switch front end: 2-FF synchronizers, sampled debounce, one-press pulses, one-hot mode sanitizer.
// Define BTN_REPEAT_EN to add auto-repeat pulses on held UP and DOWN.
module input_conditioner #(
  parameter int SAMPLE_DIV     = 100000,
  parameter int STABLE_SAMPLES = 20,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic [4:0] push_button_raw,
  input  logic [3:0] mode_raw,
  output logic [4:0] push_button_level,
  output logic [4:0] push_button_pulse,
  output logic [3:0] mode,
  output logic       mode_error,
  output logic       sample_tick
);

  localparam int NB = 9;
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int SW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(SAMPLE_DIV - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_SAMPLES - 1);

  logic [NB-1:0] sync_q1, sync_q2;
  logic [DW-1:0] div_q;
  logic [NB-1:0] level_q, level_d;
  logic [SW-1:0] stab_q [NB];
  logic [SW-1:0] stab_d [NB];
  logic [4:0]    rise, rep, pulse_q;
  logic [3:0]    mode_lvl;
  logic          multi;

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      // NOTE: non-blocking so sync_q2 takes sync_q1's old value -- a real two-stage chain.
      sync_q1 <= {mode_raw, push_button_raw};
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) div_q <= '0;
    else       div_q <= (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
  end

  assign sample_tick = (div_q == DIV_LAST);

  always_comb begin
    // NOTE: defaults first so every path assigns every bit and no latch is inferred.
    level_d = level_q;
    for (int i = 0; i < NB; i++) begin
      stab_d[i] = stab_q[i];
      if (sample_tick) begin
        if (sync_q2[i] == level_q[i]) begin
          stab_d[i] = '0;
        end else if (stab_q[i] == STABLE_LAST) begin
          level_d[i] = sync_q2[i];
          stab_d[i]  = '0;
        end else begin
          stab_d[i] = stab_q[i] + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      level_q <= '0;
      // NOTE: the counter array is ordinary flops, not a RAM, so it can and must be reset.
      for (int i = 0; i < NB; i++) stab_q[i] <= '0;
    end else begin
      level_q <= level_d;
      for (int i = 0; i < NB; i++) stab_q[i] <= stab_d[i];
    end
  end

  // level_d differs from level_q only on a tick, so rise is a tick-qualified 0->1 edge
  assign rise = level_d[4:0] & ~level_q[4:0];

`ifdef BTN_REPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam int RW = $clog2(REPEAT_RATE + 1);
  localparam logic [HW-1:0] HOLD_FULL = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

  logic [1:0] rep_k;

  for (genvar k = 0; k < 2; k++) begin : g_rep
    localparam int B = (k == 0) ? 1 : 4;
    logic [HW-1:0] hold_q;
    logic [RW-1:0] rate_q;
    logic          keep;

    // counts only ticks where the level was already high and stays high
    assign keep = level_q[B] & level_d[B];

    always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
        hold_q <= '0;
        rate_q <= '0;
      end else if (sample_tick) begin
        if (!keep) begin
          hold_q <= '0;
          rate_q <= '0;
        end else if (hold_q != HOLD_FULL) begin
          hold_q <= hold_q + HW'(1);
        end else if (rate_q == RATE_LAST) begin
          rate_q <= '0;
        end else begin
          rate_q <= rate_q + RW'(1);
        end
      end
    end

    assign rep_k[k] = sample_tick & keep &
                      ((hold_q == HOLD_LAST) | ((hold_q == HOLD_FULL) & (rate_q == RATE_LAST)));
  end

  assign rep = {rep_k[1], 2'b00, rep_k[0], 1'b0};
`else
  assign rep = '0;
`endif

  // pulse is rewritten only on ticks, so each pulse lasts exactly one tick period
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET)            pulse_q <= '0;
    else if (sample_tick) pulse_q <= rise | rep;
  end

  assign mode_lvl = level_q[8:5];
  assign multi    = |(mode_lvl & (mode_lvl - 4'd1));

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      mode       <= '0;
      mode_error <= 1'b0;
    end else begin
      mode_error <= multi;
      if (!multi) mode <= mode_lvl;
    end
  end

  assign push_button_level = level_q[4:0];
  assign push_button_pulse = pulse_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: tick-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed pulse counts, widths and mode values.
module tb_input_conditioner;

  localparam int DIV   = 10;
  localparam int STB   = 4;
  localparam int RDLY  = 8;
  localparam int RRATE = 3;

  logic       MCLK  = 1'b0;
  logic       RESET = 1'b1;
  logic [4:0] push_button_raw = '0;
  logic [3:0] mode_raw = '0;
  logic [4:0] push_button_level, push_button_pulse;
  logic [3:0] mode;
  logic       mode_error, sample_tick;

  int total = 0;
  int bad   = 0;

  input_conditioner #(
    .SAMPLE_DIV(DIV), .STABLE_SAMPLES(STB), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)
  ) dut (
    .MCLK(MCLK), .RESET(RESET),
    .push_button_raw(push_button_raw), .mode_raw(mode_raw),
    .push_button_level(push_button_level), .push_button_pulse(push_button_pulse),
    .mode(mode), .mode_error(mode_error), .sample_tick(sample_tick)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw delayed two edges, per-bit run of disagreeing ticks, hold age in ticks.
  logic [8:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_old;
  logic [4:0] m_pulse = '0, m_rep;
  logic [3:0] m_mode = '0;
  logic       m_err = 1'b0;
  int         m_n = 0;
  int         m_run [9];
  int         m_held [2];

  // Pulse monitor: rising-edge counts and width of the most recent completed pulse.
  int         rises [5];
  int         cur_w [5];
  int         last_w [5];
  logic [4:0] prev_pulse = '0;

  initial begin
    for (int i = 0; i < 9; i++) m_run[i] = 0;
    for (int i = 0; i < 2; i++) m_held[i] = 0;
    for (int i = 0; i < 5; i++) begin rises[i] = 0; cur_w[i] = 0; last_w[i] = 0; end
    forever begin
      @(posedge MCLK);
      if (RESET) begin
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0; m_mode = '0; m_err = 1'b0; m_n = 0;
        for (int i = 0; i < 9; i++) m_run[i] = 0;
        for (int i = 0; i < 2; i++) m_held[i] = 0;
      end else begin
        if ($countones(m_lvl[8:5]) <= 1) begin
          m_mode = m_lvl[8:5];
          m_err  = 1'b0;
        end else begin
          m_err = 1'b1;
        end
        if (m_n % DIV == DIV - 1) begin
          m_old = m_lvl;
          for (int i = 0; i < 9; i++) begin
            if (m_s2[i] == m_lvl[i]) m_run[i] = 0;
            else begin
              m_run[i]++;
              if (m_run[i] == STB) begin m_lvl[i] = m_s2[i]; m_run[i] = 0; end
            end
          end
          m_rep = '0;
`ifdef BTN_REPEAT_EN
          for (int k = 0; k < 2; k++) begin
            int b;
            b = (k == 0) ? 1 : 4;
            if (m_old[b] && m_lvl[b]) begin
              m_held[k]++;
              if (m_held[k] == RDLY || (m_held[k] > RDLY && (m_held[k] - RDLY) % RRATE == 0))
                m_rep[b] = 1'b1;
            end else begin
              m_held[k] = 0;
            end
          end
`endif
          m_pulse = (m_lvl[4:0] & ~m_old[4:0]) | m_rep;
        end
        m_n++;
        m_s2 = m_s1;
        m_s1 = {mode_raw, push_button_raw};
      end
      #2;
      check("level", push_button_level, m_lvl[4:0]);
      check("pulse", push_button_pulse, m_pulse);
      check("mode", mode, m_mode);
      check("mode_error", mode_error, m_err);
      check("sample_tick", sample_tick, (m_n % DIV == DIV - 1));
      for (int i = 0; i < 5; i++) begin
        if (push_button_pulse[i]) begin
          if (!prev_pulse[i]) rises[i]++;
          cur_w[i]++;
        end else if (prev_pulse[i]) begin
          last_w[i] = cur_w[i];
          cur_w[i]  = 0;
        end
      end
      prev_pulse = push_button_pulse;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic do_reset();
    @(negedge MCLK);
    push_button_raw = '0;
    mode_raw = '0;
    RESET = 1'b1;
    cycles(2);
    RESET = 1'b0;
  endtask

  task automatic snap(output int base [5]);
    for (int i = 0; i < 5; i++) base[i] = rises[i];
  endtask

  initial begin
    int base [5];
    int w;
    bit seen;
    int exp_cnt [5];

    // 1: reset mid-run with everything high, then re-qualify
    do_reset();
    push_button_raw = 5'h1f;
    mode_raw = 4'hf;
    cycles(80);
    check("s1_level_before_reset", push_button_level, 5'h1f);
    check("s1_err_before_reset", mode_error, 1'b1);
    @(negedge MCLK);
    RESET = 1'b1;
    #1;
    check("s1_rst_level", push_button_level, 5'h00);
    check("s1_rst_pulse", push_button_pulse, 5'h00);
    check("s1_rst_mode", mode, 4'h0);
    check("s1_rst_err", mode_error, 1'b0);
    check("s1_rst_tick", sample_tick, 1'b0);
    cycles(2);
    snap(base);
    RESET = 1'b0;
    cycles(80);
    check("s1_level_after", push_button_level, 5'h1f);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("s1_count_b%0d", i), rises[i] - base[i], 1);
      check($sformatf("s1_width_b%0d", i), last_w[i], DIV);
    end
    check("s1_mode_held", mode, 4'h0);
    check("s1_err_after", mode_error, 1'b1);

    // 2: bounce on UP, then steady press and release
    do_reset();
    snap(base);
    for (int seg = 0; seg < 6; seg++) begin
      push_button_raw[1] = (seg % 2 == 0);
      cycles(15);
    end
    check("s2_no_pulse_bounce", rises[1] - base[1], 0);
    check("s2_level_bounce", push_button_level[1], 1'b0);
    push_button_raw[1] = 1'b1;
    cycles(60);
    check("s2_level_held", push_button_level[1], 1'b1);
    check("s2_count_held", rises[1] - base[1], 1);
    check("s2_width", last_w[1], DIV);
    push_button_raw[1] = 1'b0;
    cycles(80);
    check("s2_count_release", rises[1] - base[1], 1);
    check("s2_level_release", push_button_level[1], 1'b0);

    // 3: CENTER and RIGHT together
    do_reset();
    snap(base);
    push_button_raw = 5'b01001;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge MCLK);
      if (push_button_pulse != 5'b0) seen = 1'b1;
    end
    check("s3_pulse_seen", seen, 1'b1);
    check("s3_pulse_vec", push_button_pulse, 5'b01001);
    w = 0;
    while (push_button_pulse == 5'b01001 && w < 50) begin
      w++;
      @(negedge MCLK);
    end
    check("s3_pulse_width", w, DIV);
    cycles(50);
    push_button_raw = '0;
    cycles(80);
    exp_cnt = '{1, 0, 0, 1, 0};
    for (int i = 0; i < 5; i++) check($sformatf("s3_count_b%0d", i), rises[i] - base[i], exp_cnt[i]);

    // 4: mode selection and multi-bit error
    do_reset();
    mode_raw = 4'b0100;
    cycles(60);
    check("s4_mode_0100", mode, 4'b0100);
    check("s4_err_0100", mode_error, 1'b0);
    mode_raw = 4'b0110;
    cycles(60);
    check("s4_mode_0110", mode, 4'b0100);
    check("s4_err_0110", mode_error, 1'b1);
    mode_raw = 4'b0010;
    cycles(60);
    check("s4_mode_0010", mode, 4'b0010);
    check("s4_err_0010", mode_error, 1'b0);

    // 5: three-tick glitch on MODE4
    mode_raw = 4'b1010;
    cycles(30);
    mode_raw = 4'b0010;
    cycles(60);
    check("s5_mode_glitch", mode, 4'b0010);
    check("s5_err_glitch", mode_error, 1'b0);

    // 6: long hold of DOWN and LEFT
    do_reset();
    snap(base);
    push_button_raw = 5'b10100;
    cycles(200);
    push_button_raw = '0;
    cycles(80);
`ifdef BTN_REPEAT_EN
    check("s6_down_count", rises[4] - base[4], 5);
`else
    check("s6_down_count", rises[4] - base[4], 1);
`endif
    check("s6_left_count", rises[2] - base[2], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
